// File: rtl/ex_operand_stage_pkg.sv
// Shared defines for the execute operand stage: instruction types,
// shift function codes and the beat record carried through the skid buffer.
package ex_operand_stage_pkg;

   // Beat fields are sized for the widest legal datapath; narrower
   // configurations zero-extend on capture and truncate on output.
   localparam int unsigned BEAT_W_MAX = 64;

   typedef enum logic [1:0] {
      TYPE_R = 2'd0,
      TYPE_I = 2'd1,
      TYPE_J = 2'd2
   } ityp_e;

   localparam logic [5:0] FUNC_SLL = 6'h00;
   localparam logic [5:0] FUNC_SRL = 6'h02;
   localparam logic [5:0] FUNC_SRA = 6'h03;

   typedef struct packed {
      ityp_e                 ityp;
      logic [5:0]            func;
      logic [BEAT_W_MAX-1:0] a;
      logic [BEAT_W_MAX-1:0] b;
      logic [BEAT_W_MAX-1:0] data;
   } beat_t;

   // Shift operations take their shifted value from rt and swap operand order.
   function automatic logic is_shift(input logic [5:0] func);
      return (func == FUNC_SLL) || (func == FUNC_SRL) || (func == FUNC_SRA);
   endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_resolve.sv
// Register operand resolution: youngest matching forwarding source wins,
// otherwise the register-file value; register 0 always reads as zero.
module fwd_resolve #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_FWD = 2
) (
   input  logic [4:0]                addr,
   input  logic [DATA_W-1:0]         rf_data,
   input  logic [NUM_FWD-1:0]        fwd_valid,
   input  logic [5*NUM_FWD-1:0]      fwd_addr,
   input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
   output logic [DATA_W-1:0]         data
);

   // Walk oldest to youngest so the lowest matching index overrides last.
   always_comb begin
      data = rf_data;
      for (int unsigned i = 0; i < NUM_FWD; i++) begin
         if (fwd_valid[(NUM_FWD-1-i) +: 1] == 1'b1 &&
             fwd_addr[(NUM_FWD-1-i)*5 +: 5] == addr) begin
            data = fwd_data[(NUM_FWD-1-i)*DATA_W +: DATA_W];
         end
      end
      if (addr == 5'd0) begin
         data = '0;
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// Execute operand stage: resolves rs/rt with forwarding, extends the
// immediate, selects ALU operands and registers the beat in a two-entry
// skid buffer so in_ready never depends on out_ready.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_FWD = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                in_ityp,
   input  logic [5:0]                in_func,
   input  logic [15:0]               in_imme,
   input  logic                      in_imm_sext,
   input  logic [4:0]                in_rs_addr,
   input  logic [4:0]                in_rt_addr,
   input  logic [DATA_W-1:0]         in_rs_data,
   input  logic [DATA_W-1:0]         in_rt_data,
   input  logic [NUM_FWD-1:0]        fwd_valid,
   input  logic [5*NUM_FWD-1:0]      fwd_addr,
   input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_a,
   output logic [DATA_W-1:0]         out_b,
   output logic [DATA_W-1:0]         out_data,
   output logic [1:0]                out_ityp,
   output logic [5:0]                out_func
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   state_e            state_q;
   beat_t             main_q;
   beat_t             skid_q;
   beat_t             in_beat;
   logic [DATA_W-1:0] rs_res;
   logic [DATA_W-1:0] rt_res;
   logic [DATA_W-1:0] imm_ext;
   logic              in_xfer;
   logic              out_xfer;

   fwd_resolve #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_rs_resolve (
      .addr      (in_rs_addr),
      .rf_data   (in_rs_data),
      .fwd_valid (fwd_valid),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data),
      .data      (rs_res)
   );

   fwd_resolve #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_rt_resolve (
      .addr      (in_rt_addr),
      .rf_data   (in_rt_data),
      .fwd_valid (fwd_valid),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data),
      .data      (rt_res)
   );

   assign imm_ext = in_imm_sext ? {{(DATA_W-16){in_imme[15]}}, in_imme}
                                : {{(DATA_W-16){1'b0}}, in_imme};

   // Assemble the incoming beat from the resolved operands and mode.
   always_comb begin
      in_beat      = '0;
      in_beat.ityp = ityp_e'(in_ityp);
      in_beat.func = in_func;
      in_beat.data = BEAT_W_MAX'(rt_res);
      case (in_beat.ityp)
         TYPE_R: begin
            in_beat.a = BEAT_W_MAX'(is_shift(in_func) ? rt_res : rs_res);
            in_beat.b = BEAT_W_MAX'(is_shift(in_func) ? rs_res : rt_res);
         end
         TYPE_I: begin
            in_beat.a = BEAT_W_MAX'(is_shift(in_func) ? rt_res : rs_res);
            in_beat.b = BEAT_W_MAX'(imm_ext);
         end
         default: begin
            in_beat.a = BEAT_W_MAX'(rs_res);
            in_beat.b = BEAT_W_MAX'(imm_ext);
         end
      endcase
   end

   assign in_ready  = (state_q != S_TWO) && !rst;
   assign out_valid = (state_q != S_EMPTY);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   assign out_a    = DATA_W'(main_q.a);
   assign out_b    = DATA_W'(main_q.b);
   assign out_data = DATA_W'(main_q.data);
   assign out_ityp = main_q.ityp;
   assign out_func = main_q.func;

   // Skid-buffer occupancy FSM; main always holds the oldest beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (flush) begin
         state_q <= S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_xfer) begin
                  main_q  <= in_beat;
                  state_q <= S_ONE;
               end
            end
            S_ONE: begin
               case ({in_xfer, out_xfer})
                  2'b11: main_q <= in_beat;
                  2'b10: begin
                     skid_q  <= in_beat;
                     state_q <= S_TWO;
                  end
                  2'b01: state_q <= S_EMPTY;
                  default: ;
               endcase
            end
            S_TWO: begin
               if (out_xfer) begin
                  main_q  <= skid_q;
                  state_q <= S_ONE;
               end
            end
            default: state_q <= S_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed vectors, multi-cycle
// corner sequences and randomized traffic checked against a queue model.
module tb_ex_operand_stage;
   import ex_operand_stage_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned NF = 2;
   localparam logic [5:0]  FUNC_ADD = 6'h20;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         in_ityp;
   logic [5:0]         in_func;
   logic [15:0]        in_imme;
   logic               in_imm_sext;
   logic [4:0]         in_rs_addr;
   logic [4:0]         in_rt_addr;
   logic [DW-1:0]      in_rs_data;
   logic [DW-1:0]      in_rt_data;
   logic [NF-1:0]      fwd_valid;
   logic [5*NF-1:0]    fwd_addr;
   logic [DW*NF-1:0]   fwd_data;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [DW-1:0]      out_a;
   logic [DW-1:0]      out_b;
   logic [DW-1:0]      out_data;
   logic [1:0]         out_ityp;
   logic [5:0]         out_func;

   always #5 clk = ~clk;

   ex_operand_stage #(.DATA_W(DW), .NUM_FWD(NF)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ityp     (in_ityp),
      .in_func     (in_func),
      .in_imme     (in_imme),
      .in_imm_sext (in_imm_sext),
      .in_rs_addr  (in_rs_addr),
      .in_rt_addr  (in_rt_addr),
      .in_rs_data  (in_rs_data),
      .in_rt_data  (in_rt_data),
      .fwd_valid   (fwd_valid),
      .fwd_addr    (fwd_addr),
      .fwd_data    (fwd_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_data    (out_data),
      .out_ityp    (out_ityp),
      .out_func    (out_func)
   );

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] d;
      logic [1:0]    ityp;
      logic [5:0]    func;
   } exp_t;

   typedef struct {
      logic [1:0]    ityp;
      logic [5:0]    func;
      logic [15:0]   imme;
      logic          sext;
      logic [4:0]    rs_addr;
      logic [4:0]    rt_addr;
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [1:0]    fv;
      logic [4:0]    fa0;
      logic [4:0]    fa1;
      logic [DW-1:0] fd0;
      logic [DW-1:0] fd1;
      logic [DW-1:0] ea;
      logic [DW-1:0] eb;
      logic [DW-1:0] ed;
   } vec_t;

   exp_t q[$];
   vec_t vecs[9];
   int   n_vec  = 0;
   int   n_mis  = 0;
   int   n_emit = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Operand value as the register-read rules define it.
   function automatic logic [DW-1:0] ref_reg(input logic [4:0] addr, input logic [DW-1:0] rf);
      if (addr == 5'd0) return '0;
      for (int i = 0; i < int'(NF); i++) begin
         if (fwd_valid[i] && fwd_addr[i*5 +: 5] == addr) return fwd_data[i*DW +: DW];
      end
      return rf;
   endfunction

   function automatic exp_t ref_beat();
      exp_t          e;
      logic [DW-1:0] rs, rt, imm;
      logic          sh;
      rs  = ref_reg(in_rs_addr, in_rs_data);
      rt  = ref_reg(in_rt_addr, in_rt_data);
      imm = in_imm_sext ? DW'($signed(in_imme)) : DW'(in_imme);
      sh  = (in_func == FUNC_SLL) || (in_func == FUNC_SRL) || (in_func == FUNC_SRA);
      e.ityp = in_ityp;
      e.func = in_func;
      e.d    = rt;
      if (in_ityp == TYPE_R) begin
         e.a = sh ? rt : rs;
         e.b = sh ? rs : rt;
      end else if (in_ityp == TYPE_I && sh) begin
         e.a = rt;
         e.b = imm;
      end else begin
         e.a = rs;
         e.b = imm;
      end
      return e;
   endfunction

   // One clock of traffic: check outputs against the model, advance it, clock.
   task automatic step();
      int occ;
      occ = q.size();
      chk("in_ready", in_ready, (occ < 2));
      chk("out_valid", out_valid, (occ > 0));
      if (occ > 0) begin
         chk("out_a", out_a, q[0].a);
         chk("out_b", out_b, q[0].b);
         chk("out_data", out_data, q[0].d);
         chk("out_ityp", out_ityp, q[0].ityp);
         chk("out_func", out_func, q[0].func);
      end
      if (flush) begin
         q.delete();
      end else begin
         if (occ > 0 && out_ready) begin
            void'(q.pop_front());
            n_emit++;
         end
         if (in_valid && occ < 2) q.push_back(ref_beat());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_plain(input logic [DW-1:0] rs_val);
      in_ityp     = TYPE_R;
      in_func     = FUNC_ADD;
      in_imme     = '0;
      in_imm_sext = 1'b0;
      in_rs_addr  = 5'd5;
      in_rt_addr  = 5'd6;
      in_rs_data  = rs_val;
      in_rt_data  = 32'h20;
      fwd_valid   = '0;
      fwd_addr    = '0;
      fwd_data    = '0;
   endtask

   initial begin
      int nb;
      int emit0;
      //            ityp    func      imme     sx  rs  rt  rs_data        rt_data        fv     fa0 fa1 fd0    fd1    ea             eb             ed
      vecs[0] = '{TYPE_R, FUNC_ADD, 16'h0000, 0, 5,  6,  32'h10,        32'h20,        2'b00, 0,  0,  32'h0, 32'h0, 32'h10,        32'h20,        32'h20};
      vecs[1] = '{TYPE_R, FUNC_ADD, 16'h0000, 0, 5,  6,  32'h11,        32'h20,        2'b11, 5,  5,  32'hAA, 32'hBB, 32'hAA,      32'h20,        32'h20};
      vecs[2] = '{TYPE_R, FUNC_ADD, 16'h0000, 0, 0,  6,  32'h55,        32'h20,        2'b01, 0,  0,  32'hCC, 32'h0, 32'h0,        32'h20,        32'h20};
      vecs[3] = '{TYPE_R, FUNC_SLL, 16'h0000, 0, 3,  4,  32'h3,         32'h1,         2'b00, 0,  0,  32'h0, 32'h0, 32'h1,         32'h3,         32'h1};
      vecs[4] = '{TYPE_I, FUNC_SRA, 16'h0004, 1, 3,  4,  32'h3,         32'h80000000,  2'b00, 0,  0,  32'h0, 32'h0, 32'h80000000,  32'h4,         32'h80000000};
      vecs[5] = '{TYPE_I, FUNC_ADD, 16'h8000, 1, 5,  6,  32'h10,        32'h20,        2'b00, 0,  0,  32'h0, 32'h0, 32'h10,        32'hFFFF8000,  32'h20};
      vecs[6] = '{TYPE_I, FUNC_ADD, 16'h8000, 0, 5,  6,  32'h10,        32'h20,        2'b00, 0,  0,  32'h0, 32'h0, 32'h10,        32'h00008000,  32'h20};
      vecs[7] = '{TYPE_J, FUNC_ADD, 16'h1234, 0, 5,  6,  32'h10,        32'h20,        2'b10, 0,  6,  32'h0, 32'h77, 32'h10,       32'h1234,      32'h77};
      vecs[8] = '{TYPE_R, FUNC_ADD, 16'h0000, 0, 5,  6,  32'h10,        32'h20,        2'b11, 7,  5,  32'h99, 32'hBB, 32'hBB,      32'h20,        32'h20};

      // Reset state
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      set_plain('0);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ityp", out_ityp, 0);
      chk("rst_out_func", out_func, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rel_in_ready", in_ready, 1);

      // Directed vectors, one beat at a time through an empty buffer
      for (int i = 0; i < 9; i++) begin
         in_ityp     = vecs[i].ityp;
         in_func     = vecs[i].func;
         in_imme     = vecs[i].imme;
         in_imm_sext = vecs[i].sext;
         in_rs_addr  = vecs[i].rs_addr;
         in_rt_addr  = vecs[i].rt_addr;
         in_rs_data  = vecs[i].rs_data;
         in_rt_data  = vecs[i].rt_data;
         fwd_valid   = vecs[i].fv;
         fwd_addr    = {vecs[i].fa1, vecs[i].fa0};
         fwd_data    = {vecs[i].fd1, vecs[i].fd0};
         in_valid    = 1'b1;
         out_ready   = 1'b1;
         step();
         in_valid = 1'b0;
         chk($sformatf("v%0d_valid", i), out_valid, 1);
         chk($sformatf("v%0d_a", i), out_a, vecs[i].ea);
         chk($sformatf("v%0d_b", i), out_b, vecs[i].eb);
         chk($sformatf("v%0d_data", i), out_data, vecs[i].ed);
         step();
      end

      // Stalled output with a continuous input stream
      nb = 0;
      emit0 = n_emit;
      for (int c = 0; c < 8; c++) begin
         logic acc;
         set_plain(32'd100 + 32'(nb));
         out_ready = (c >= 3);
         in_valid  = (nb < 3);
         if (c == 2) chk("stall_in_ready_low", in_ready, 0);
         acc = in_valid && in_ready;
         step();
         if (acc) nb++;
      end
      chk("stall_emitted", n_emit - emit0, 3);
      chk("stall_drained", q.size(), 0);

      // Flush while full, with a new beat offered in the same cycle
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_plain(32'h200); step();
      set_plain(32'h201); step();
      set_plain(32'hDEAD);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("flush_out_valid", out_valid, 0);
      repeat (3) step();

      // Reset asserted while holding one beat
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_plain(32'h300); step();
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_a", out_a, 0);
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_rel_in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (3) step();

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         flush       = ($urandom_range(0, 19) == 0);
         in_ityp     = 2'($urandom_range(0, 2));
         in_func     = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom);
         in_imme     = 16'($urandom);
         in_imm_sext = 1'($urandom);
         in_rs_addr  = 5'($urandom_range(0, 7));
         in_rt_addr  = 5'($urandom_range(0, 7));
         in_rs_data  = $urandom;
         in_rt_data  = $urandom;
         fwd_valid   = NF'($urandom);
         fwd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         fwd_data    = {$urandom, $urandom};
         step();
      end

      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      chk("final_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter NUM_FWD, default 2: number of forwarding sources; legal range 1..4.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid  in  1 and in_ready  out  1: upstream handshake.
REQ-006 SHALL have ports in_ityp  in  2 (TYPE_R/I/J), in_func  in  6, in_imme  in  16 (raw immediate) and in_imm_sext  in  1 (1 = sign-extend, 0 = zero-extend).
REQ-007 SHALL have ports in_rs_addr  in  5, in_rt_addr  in  5, in_rs_data  in  DATA_W and in_rt_data  in  DATA_W: register-file values.
REQ-008 SHALL have ports fwd_valid  in  NUM_FWD, fwd_addr  in  5*NUM_FWD and fwd_data  in  DATA_W*NUM_FWD: forwarding sources; index 0 = youngest = highest priority.
REQ-009 SHALL have port flush  in  1: discard all held beats.
REQ-010 SHALL have ports out_valid  out  1 and out_ready  in  1: downstream handshake.
REQ-011 SHALL have ports out_a  out  DATA_W, out_b  out  DATA_W, out_data  out  DATA_W (resolved rt, for stores), out_ityp  out  2 and out_func  out  6.

Function
REQ-012 SHALL resolve rs at the input transfer: rs = fwd_data[i] for the lowest i with fwd_valid[i]=1 and fwd_addr[i]==in_rs_addr; otherwise rs = in_rs_data.
REQ-013 SHALL resolve rt the same way as rs.
REQ-014 SHALL force a resolved operand to 0 when its address is 0, regardless of forwarding or register-file data.
REQ-015 SHALL extend in_imme to DATA_W: sign-extend when in_imm_sext=1, zero-extend otherwise.
REQ-016 SHALL select operands by mode:
- TYPE_R, func in {FUNC_SLL, FUNC_SRL, FUNC_SRA}: a=rt, b=rs.
- TYPE_R, any other func: a=rs, b=rt.
- TYPE_I, func in the shift set: a=rt, b=imm.
- TYPE_I otherwise, and TYPE_J: a=rs, b=imm.
REQ-017 SHALL drive out_data = resolved rt in every mode.
REQ-018 SHALL register all outputs: a beat accepted in cycle N is presented with out_valid=1 in cycle N+1 at the earliest.
REQ-019 SHALL hold a two-entry skid buffer (main, skid) with occupancy states EMPTY, ONE and TWO.
REQ-020 SHALL drive in_ready=1 exactly when state != TWO; in_ready SHALL NOT depend combinationally on out_ready.
REQ-021 SHALL count an input transfer when in_valid & in_ready, and an output transfer when out_valid & out_ready.
REQ-022 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-023 SHALL make state transitions as follows:
- EMPTY to ONE on input transfer.
- ONE to EMPTY on output transfer without input transfer.
- ONE to TWO on input transfer without output transfer.
- ONE stays ONE on simultaneous input and output transfer: the new beat becomes main.
- TWO to ONE on output transfer: skid moves to main.
REQ-024 SHALL preserve beat order; no beat SHALL be duplicated or dropped except by flush.
REQ-025 SHALL, on flush=1, go to EMPTY with out_valid=0 next cycle and discard any input beat offered in that same cycle; flush SHALL take priority over all simultaneous events.
REQ-026 SHALL not sample forwarding inputs again for a beat already captured in main or skid.

Reset
REQ-027 SHALL, while rst=1, force state EMPTY, out_valid=0, in_ready=0 and out_a/out_b/out_data/out_ityp/out_func=0.
REQ-028 SHALL assert in_ready=1 in the first cycle after rst deasserts.
REQ-029 SHALL discard held beats when rst asserts mid-operation; no beat SHALL be emitted after release unless newly accepted.

Structure
REQ-030 SHALL take TYPE_R/I/J, FUNC_SLL/SRL/SRA and a packed beat struct {ityp, func, a, b, data} from the shared defines package.
REQ-031 SHALL implement operand resolution (REQ-012..014) in one sub-module, fwd_resolve, instantiated once for rs and once for rt.

Verification
REQ-032 SHALL cover: R-type ADD with rs=5 (0x10), rt=6 (0x20), no forwarding -> next cycle a=0x10, b=0x20, data=0x20.
REQ-033 SHALL cover: fwd0 and fwd1 both valid with addr 5, data 0xAA and 0xBB -> rs=0xAA; rs_addr=0 with fwd0 addr 0 valid -> rs=0.
REQ-034 SHALL cover: TYPE_R FUNC_SLL, rs=3, rt=0x1 -> a=0x1, b=0x3; TYPE_I FUNC_SRA, imme=4 -> a=rt, b=4.
REQ-035 SHALL cover: imme=0x8000 -> sext=1 gives 0xFFFF8000, sext=0 gives 0x00008000 (DATA_W=64: 0xFFFFFFFFFFFF8000).
REQ-036 SHALL cover: out_ready=0 for 3 cycles with a continuous input stream -> in_ready drops after 2 beats; beats emitted in order with no loss once out_ready=1.
REQ-037 SHALL cover: flush in state TWO together with in_valid=1 -> out_valid=0 next cycle, that input beat never emitted; rst asserted in state ONE -> out_valid=0 immediately.
